// File: rtl/toggle_event_decoder.sv
// Toggle-encoded event receiver: synchronizes tog_in, recovers each level
// change as one token, queues tokens behind a valid/ready handshake, and
// keeps a wrapping accepted-event count plus a sticky drop flag.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_DISABLED | decoder off; no tokens created, pending tokens still drainable
// ST_ALIGN    | one cycle; adopt the synchronized level without a token
// ST_RUN      | each synchronized level change creates one token
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tog_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  ev_count,
  output logic              ovf,
  input  logic              clr_ovf,
  output logic              level
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ALIGN    = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     sync_out;
  logic                     level_q;
  logic [PEND_W-1:0]        pend_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_q;
  logic                     tgl;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     drop;
  logic                     level_ld;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign full     = (pend_q == PEND_MAX);
  assign ev_valid = (pend_q != '0);
  assign pop      = ev_valid && ev_ready;
  assign drop     = push && !pop && full;

  assign pending  = pend_q;
  assign ev_count = cnt_q;
  assign ovf      = ovf_q;
  assign level    = level_q;

  // Synchronizer chain on the asynchronous toggle line; runs in every state.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_DISABLED;
    else     state_q <= state_d;
  end

  // Next-state, token creation and reference-level load decode.
  always_comb begin
    state_d  = state_q;
    level_ld = 1'b0;
    push     = 1'b0;
    tgl      = (sync_out != level_q);
    case (state_q)
      ST_DISABLED: begin
        if (en) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        level_ld = 1'b1;
        state_d  = en ? ST_RUN : ST_DISABLED;
      end
      ST_RUN: begin
        push     = tgl;
        level_ld = tgl;
        if (!en) state_d = ST_DISABLED;
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  // Reference level, pending tokens, event count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      pend_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (level_ld) level_q <= sync_out;
      // A simultaneous pop frees a slot, so push+pop never overflows.
      if (push && pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (push && !full) begin
        pend_q <= pend_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end else if (pop) begin
        pend_q <= pend_q - 1'b1;
      end
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

endmodule
